// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter driving open-drain clock/data via low-side enables.
// Latency: accept -> INHIBIT_CYCLES of clock inhibit -> 1 RTS cycle -> 11 device clocks -> done/err pulse.
// Backpressure: tx_ready is high only in IDLE; tx_valid while busy is dropped, never queued.
// Optional feature: define PS2_TX_RETRY_EN to retry a byte once after a NACK or timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_vga,
  input  logic       reset_btn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clock_i,
  input  logic       ps2_data_i,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE
  } state_t;

  state_t                   state;
  logic [SYNC_STAGES-1:0]   clk_sync;
  logic [SYNC_STAGES-1:0]   dat_sync;
  logic                     clk_prev;
  logic                     clk_s;
  logic                     dat_s;
  logic                     fall;
  logic [INH_W-1:0]         inh_cnt;
  logic [TO_W-1:0]          to_cnt;
  logic [3:0]               bit_cnt;
  logic [8:0]               byte_q;   // {odd parity, data} kept intact for a retry
  logic [8:0]               shreg;    // shifted out LSB first during SEND
  logic                     in_xfer;
  logic                     timeout_hit;
  logic                     nack_hit;
  logic                     fail;
`ifdef PS2_TX_RETRY_EN
  logic                     retry_used;
`endif

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign dat_s    = dat_sync[SYNC_STAGES-1];
  assign fall     = clk_prev & ~clk_s;
  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Timeout outranks a clock fall arriving in the same cycle.
  assign in_xfer     = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign timeout_hit = in_xfer && (to_cnt == TO_LIMIT);
  assign nack_hit    = (state == ACK) && fall && dat_s && !timeout_hit;
  assign fail        = timeout_hit || nack_hit;

  // Synchronize the raw lines; idle level is high so reset to 1 to avoid a false fall.
  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clock_i};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev <= clk_s;
    end
  end

  // Transmit FSM with registered line enables and result pulses.
  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      state        <= IDLE;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
      tx_done      <= 1'b0;
      tx_err       <= 1'b0;
      inh_cnt      <= '0;
      to_cnt       <= '0;
      bit_cnt      <= '0;
      byte_q       <= '0;
      shreg        <= '0;
`ifdef PS2_TX_RETRY_EN
      retry_used   <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      if (fail) begin
        ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
        if (!retry_used) begin
          retry_used   <= 1'b1;
          ps2_clock_oe <= 1'b1;
          inh_cnt      <= '0;
          state        <= INHIBIT;
        end else begin
          ps2_clock_oe <= 1'b0;
          tx_err       <= 1'b1;
          state        <= IDLE;
        end
`else
        ps2_clock_oe <= 1'b0;
        tx_err       <= 1'b1;
        state        <= IDLE;
`endif
      end else begin
        if (in_xfer && (to_cnt != TO_LIMIT)) to_cnt <= to_cnt + 1'b1;
        case (state)
          IDLE: begin
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            if (tx_valid) begin
              byte_q       <= {~^tx_data, tx_data};
              inh_cnt      <= '0;
              ps2_clock_oe <= 1'b1;
              state        <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
              retry_used   <= 1'b0;
`endif
            end
          end
          INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2_data_oe  <= 1'b1;   // start bit, then release clock in the same cycle
              ps2_clock_oe <= 1'b0;
              state        <= RTS;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          RTS: begin
            to_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= byte_q;
            state   <= SEND;
          end
          SEND: begin
            if (fall) begin
              if (bit_cnt == 4'd9) begin
                ps2_data_oe <= 1'b0;  // stop bit
                state       <= ACK;
              end else begin
                ps2_data_oe <= ~shreg[0];
                shreg       <= {1'b0, shreg[8:1]};
                bit_cnt     <= bit_cnt + 1'b1;
              end
            end
          end
          ACK: begin
            if (fall) state <= WAIT_IDLE;  // data high here is handled as NACK above
          end
          WAIT_IDLE: begin
            if (clk_s && dat_s) begin
              tx_done <= 1'b1;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the open-drain lines.
module tb_ps2_host_tx;
  localparam int INH = 600;
  localparam int TO  = 5000;
  localparam int H   = 40;

  logic       clk_vga = 1'b0;
  logic       reset_btn = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, busy, ps2_clock_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clock_i, ps2_data_i;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int bad_cnt = 0;

  assign ps2_clock_i = ~(ps2_clock_oe | dev_clk_low);
  assign ps2_data_i  = ~(ps2_data_oe | dev_data_low);

  always #5 clk_vga = ~clk_vga;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk_vga(clk_vga), .reset_btn(reset_btn), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .busy(busy),
    .ps2_clock_i(ps2_clock_i), .ps2_data_i(ps2_data_i),
    .ps2_clock_oe(ps2_clock_oe), .ps2_data_oe(ps2_data_oe)
  );

  always @(negedge clk_vga) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if ((tx_done && tx_err) || ((tx_done || tx_err) && !tx_ready)) bad_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic request(input logic [7:0] b);
    @(negedge clk_vga);
    tx_data = b; tx_valid = 1'b1;
    @(negedge clk_vga);
    tx_valid = 1'b0;
  endtask

  // Device side: wait for request-to-send, clock 10 bits sampling on rising edges, then ACK/NACK.
  task automatic dev_xfer(input bit nack, output int inh_len, output logic start_bit,
                          output logic clk_oe_at_rts, output logic [9:0] bits, output bit timed_out);
    int guard = 0;
    inh_len = 0; start_bit = 1'b1; clk_oe_at_rts = 1'b1; bits = '0; timed_out = 1'b0;
    while (!ps2_data_oe && guard < 4*INH + 100) begin
      @(negedge clk_vga);
      guard++;
      if (ps2_clock_oe && !ps2_data_oe) inh_len++;
    end
    if (!ps2_data_oe) begin timed_out = 1'b1; return; end
    start_bit = ps2_data_i;
    clk_oe_at_rts = ps2_clock_oe;
    repeat (10) @(negedge clk_vga);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1; repeat (H) @(negedge clk_vga);
      dev_clk_low = 1'b0; bits[i] = ps2_data_i; repeat (H) @(negedge clk_vga);
    end
    if (!nack) dev_data_low = 1'b1;
    repeat (5) @(negedge clk_vga);
    dev_clk_low = 1'b1; repeat (H) @(negedge clk_vga);
    dev_clk_low = 1'b0; repeat (5) @(negedge clk_vga);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_settle(input int d0, input int e0);
    int g = 0;
    while (done_cnt == d0 && err_cnt == e0 && g < 500) begin @(negedge clk_vga); g++; end
    repeat (20) @(negedge clk_vga);
  endtask

  task automatic test_reset();
    reset_btn = 1'b1;
    repeat (3) @(negedge clk_vga);
    tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (tx_done !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
    tests_run++; if (tx_err !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_err: got %b want 0", tx_err); end
    tests_run++; if (ps2_clock_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_clock_oe: got %b want 0", ps2_clock_oe); end
    tests_run++; if (ps2_data_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); end
    reset_btn = 1'b0;
    repeat (2) @(negedge clk_vga);
  endtask

  // exp_bits = {stop, parity, data}; parity supplied by the caller, worked out by hand.
  task automatic test_send(input logic [7:0] b, input logic [9:0] exp_bits);
    int inh_len, d0, e0;
    logic sb, crel;
    logic [9:0] bits;
    bit to;
    d0 = done_cnt; e0 = err_cnt;
    fork
      request(b);
      dev_xfer(1'b0, inh_len, sb, crel, bits, to);
    join
    wait_settle(d0, e0);
    tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL send_%h_rts_seen: timed out=%b want 0", b, to); end
    tests_run++; if (inh_len !== INH) begin tests_failed++; $display("FAIL send_%h_inhibit_len: got %0d want %0d", b, inh_len, INH); end
    tests_run++; if (sb !== 1'b0) begin tests_failed++; $display("FAIL send_%h_start_bit: got %b want 0", b, sb); end
    tests_run++; if (crel !== 1'b0) begin tests_failed++; $display("FAIL send_%h_clock_release_at_rts: got %b want 0", b, crel); end
    tests_run++; if (bits !== exp_bits) begin tests_failed++; $display("FAIL send_%h_bits: got %b want %b", b, bits, exp_bits); end
    tests_run++; if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL send_%h_done_pulses: got %0d want 1", b, done_cnt - d0); end
    tests_run++; if (err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL send_%h_err_pulses: got %0d want 0", b, err_cnt - e0); end
  endtask

  task automatic test_nack();
    int inh_len, d0, e0;
    logic sb, crel;
    logic [9:0] bits;
    bit to;
    d0 = done_cnt; e0 = err_cnt;
    fork
      request(8'hF4);
      dev_xfer(1'b1, inh_len, sb, crel, bits, to);
    join
    // F4 has five ones, so the odd-parity bit is 0.
    tests_run++; if (bits !== 10'b10_1111_0100) begin tests_failed++; $display("FAIL nack_bits: got %b want %b", bits, 10'b10_1111_0100); end
`ifdef PS2_TX_RETRY_EN
    repeat (20) @(negedge clk_vga);
    tests_run++; if (err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL nack_first_err_suppressed: got %0d want 0", err_cnt - e0); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL nack_retry_busy: got %b want 1", busy); end
    dev_xfer(1'b1, inh_len, sb, crel, bits, to);
    tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL nack_retry_rts_seen: timed out=%b want 0", to); end
`endif
    wait_settle(d0, e0);
    tests_run++; if (err_cnt - e0 !== 1) begin tests_failed++; $display("FAIL nack_err_pulses: got %0d want 1", err_cnt - e0); end
    tests_run++; if (done_cnt - d0 !== 0) begin tests_failed++; $display("FAIL nack_done_pulses: got %0d want 0", done_cnt - d0); end
    tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL nack_ready_after: got %b want 1", tx_ready); end
  endtask

  task automatic test_timeout();
    int n, d0, exp_n;
    d0 = done_cnt;
`ifdef PS2_TX_RETRY_EN
    exp_n = 2 * (1 + INH + 1 + TO);
`else
    exp_n = 1 + INH + 1 + TO;
`endif
    @(negedge clk_vga);
    tx_data = 8'h12; tx_valid = 1'b1;
    @(negedge clk_vga);
    tx_valid = 1'b0;
    n = 0;
    while (!tx_err && n < 3 * exp_n) begin @(negedge clk_vga); n++; end
    tests_run++; if (n < exp_n - 1 || n > exp_n + 1) begin tests_failed++; $display("FAIL timeout_latency: got %0d cycles want %0d", n, exp_n); end
    tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL timeout_ready_with_err: got %b want 1", tx_ready); end
    @(negedge clk_vga);
    tests_run++; if ({ps2_clock_oe, ps2_data_oe} !== 2'b00) begin tests_failed++; $display("FAIL timeout_lines_released: got %b want 00", {ps2_clock_oe, ps2_data_oe}); end
    tests_run++; if (tx_err !== 1'b0) begin tests_failed++; $display("FAIL timeout_err_width: got %b want 0", tx_err); end
    tests_run++; if (done_cnt - d0 !== 0) begin tests_failed++; $display("FAIL timeout_done_pulses: got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int d0, e0, g;
    logic oe_before;
    d0 = done_cnt; e0 = err_cnt;
    oe_before = 1'b0;
    fork
      request(8'hA5);
      begin
        g = 0;
        while (!ps2_data_oe && g < 4*INH) begin @(negedge clk_vga); g++; end
        repeat (10) @(negedge clk_vga);
        for (int i = 0; i < 3; i++) begin
          dev_clk_low = 1'b1; repeat (H) @(negedge clk_vga);
          dev_clk_low = 1'b0; repeat (H) @(negedge clk_vga);
        end
        dev_clk_low = 1'b1;
        repeat (10) @(negedge clk_vga);
      end
    join
    // A5 bit 3 is 0, so the host is pulling data low after the 4th fall.
    oe_before = ps2_data_oe;
    tests_run++; if (oe_before !== 1'b1) begin tests_failed++; $display("FAIL rstmid_data_driven_before: got %b want 1", oe_before); end
    #3 reset_btn = 1'b1;
    #1;
    tests_run++; if ({ps2_clock_oe, ps2_data_oe} !== 2'b00) begin tests_failed++; $display("FAIL rstmid_async_release: got %b want 00", {ps2_clock_oe, ps2_data_oe}); end
    tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_ready: got %b want 1", tx_ready); end
    dev_clk_low = 1'b0;
    @(negedge clk_vga);
    reset_btn = 1'b0;
    repeat (20) @(negedge clk_vga);
    tests_run++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL rstmid_no_pulses: got done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0); end
    test_send(8'hFF, 10'b11_1111_1111);
  endtask

  task automatic test_back_to_back();
    int inh_len, d0, e0;
    logic sb, crel, stray, busy_at_pulse;
    logic [9:0] bits;
    bit to;
    d0 = done_cnt; e0 = err_cnt;
    busy_at_pulse = 1'b0;
    fork
      begin
        request(8'hED);
        repeat (50) @(negedge clk_vga);
        tx_data = 8'h55; tx_valid = 1'b1; busy_at_pulse = busy;
        @(negedge clk_vga);
        tx_valid = 1'b0;
      end
      dev_xfer(1'b0, inh_len, sb, crel, bits, to);
    join
    wait_settle(d0, e0);
    tests_run++; if (busy_at_pulse !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy_at_second_valid: got %b want 1", busy_at_pulse); end
    tests_run++; if (bits !== 10'b11_1110_1101) begin tests_failed++; $display("FAIL b2b_bits: got %b want %b", bits, 10'b11_1110_1101); end
    stray = 1'b0;
    repeat (300) begin @(negedge clk_vga); if (busy || ps2_clock_oe) stray = 1'b1; end
    tests_run++; if (stray !== 1'b0) begin tests_failed++; $display("FAIL b2b_second_byte_ignored: busy seen=%b want 0", stray); end
    tests_run++; if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL b2b_done_pulses: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_pulse_rules();
    tests_run++; if (bad_cnt !== 0) begin tests_failed++; $display("FAIL pulse_rules: got %0d bad cycles want 0", bad_cnt); end
  endtask

  initial begin
    test_reset();
    test_send(8'hED, 10'b11_1110_1101);
    test_send(8'h01, 10'b10_0000_0001);
    test_send(8'h00, 10'b11_0000_0000);
    test_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_pulse_rules();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
